// File: rtl/tap_controller_if.sv
// TAP pin bundle: serial scan pins, boundary-chain controls and debug state.
// The tester side uses master, the TAP controller uses slave.
interface tap_controller_if;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdo_en;
    logic       bsr_tdo;
    logic       bsr_shift;
    logic       bsr_clk_en;
    logic       bsr_update;
    logic       bsr_mode;
    logic [3:0] state;

    modport master (
        output tms, tdi, bsr_tdo,
        input  tdo, tdo_en, bsr_shift, bsr_clk_en, bsr_update, bsr_mode, state
    );

    modport slave (
        input  tms, tdi, bsr_tdo,
        output tdo, tdo_en, bsr_shift, bsr_clk_en, bsr_update, bsr_mode, state
    );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM, 4-bit IR, IDCODE/BYPASS DRs, boundary-chain control.
// Latency: state/shift on rising TCK, tdo/tdo_en on falling TCK; no backpressure (TCK-paced).
module tap_controller #(
    parameter logic [31:0] IDCODE = 32'h1000_0001
) (
    input  logic            clk,
    input  logic            trst_n,
    tap_controller_if.slave tap
);

    localparam logic [3:0] TLR    = 4'd0;
    localparam logic [3:0] RTI    = 4'd1;
    localparam logic [3:0] SEL_DR = 4'd2;
    localparam logic [3:0] CAP_DR = 4'd3;
    localparam logic [3:0] SH_DR  = 4'd4;
    localparam logic [3:0] EX1_DR = 4'd5;
    localparam logic [3:0] PAU_DR = 4'd6;
    localparam logic [3:0] EX2_DR = 4'd7;
    localparam logic [3:0] UPD_DR = 4'd8;
    localparam logic [3:0] SEL_IR = 4'd9;
    localparam logic [3:0] CAP_IR = 4'd10;
    localparam logic [3:0] SH_IR  = 4'd11;
    localparam logic [3:0] EX1_IR = 4'd12;
    localparam logic [3:0] PAU_IR = 4'd13;
    localparam logic [3:0] EX2_IR = 4'd14;
    localparam logic [3:0] UPD_IR = 4'd15;

    localparam logic [3:0] OP_EXTEST = 4'b0000;
    localparam logic [3:0] OP_SAMPLE = 4'b0001;
    localparam logic [3:0] OP_IDCODE = 4'b0010;

    localparam logic [3:0] IR_CAPTURE = 4'b0101;

    // Bit 0 of an IEEE ID code is always 1; guard against a bad override.
    localparam logic [31:0] ID_VALUE = {IDCODE[31:1], 1'b1};

    logic        rst_n;
    logic [3:0]  state_q;
    logic [3:0]  state_nxt;
    logic [3:0]  ir_q;
    logic [3:0]  ir_sr;
    logic [31:0] id_sr;
    logic        bypass_q;
    logic        sel_bsr;
    logic        sel_id;
    logic        sel_byp;
    logic        dr_tdo;
    logic        tdo_q;
    logic        tdo_en_q;
    logic        bsr_update_q;

    // Assert asynchronously, release after one TCK so the FSM first moves on the second edge.
    always_ff @(posedge clk or negedge trst_n) begin
        if (!trst_n) begin
            rst_n <= 1'b0;
        end else begin
            rst_n <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            TLR:     state_nxt = tap.tms ? TLR    : RTI;
            RTI:     state_nxt = tap.tms ? SEL_DR : RTI;
            SEL_DR:  state_nxt = tap.tms ? SEL_IR : CAP_DR;
            CAP_DR:  state_nxt = tap.tms ? EX1_DR : SH_DR;
            SH_DR:   state_nxt = tap.tms ? EX1_DR : SH_DR;
            EX1_DR:  state_nxt = tap.tms ? UPD_DR : PAU_DR;
            PAU_DR:  state_nxt = tap.tms ? EX2_DR : PAU_DR;
            EX2_DR:  state_nxt = tap.tms ? UPD_DR : SH_DR;
            UPD_DR:  state_nxt = tap.tms ? SEL_DR : RTI;
            SEL_IR:  state_nxt = tap.tms ? TLR    : CAP_IR;
            CAP_IR:  state_nxt = tap.tms ? EX1_IR : SH_IR;
            SH_IR:   state_nxt = tap.tms ? EX1_IR : SH_IR;
            EX1_IR:  state_nxt = tap.tms ? UPD_IR : PAU_IR;
            PAU_IR:  state_nxt = tap.tms ? EX2_IR : PAU_IR;
            EX2_IR:  state_nxt = tap.tms ? UPD_IR : SH_IR;
            UPD_IR:  state_nxt = tap.tms ? SEL_DR : RTI;
            default: state_nxt = TLR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TLR;
        end else begin
            state_q <= state_nxt;
        end
    end

    // IR is forced on the edge entering TLR so it already reads IDCODE while in TLR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_sr <= IR_CAPTURE;
            ir_q  <= OP_IDCODE;
        end else begin
            if (state_q == CAP_IR) begin
                ir_sr <= IR_CAPTURE;
            end else if (state_q == SH_IR) begin
                ir_sr <= {tap.tdi, ir_sr[3:1]};
            end
            if (state_nxt == TLR) begin
                ir_q <= OP_IDCODE;
            end else if (state_q == UPD_IR) begin
                ir_q <= ir_sr;
            end
        end
    end

    assign sel_bsr = (ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE);
    assign sel_id  = (ir_q == OP_IDCODE);
    assign sel_byp = !sel_bsr && !sel_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_sr    <= ID_VALUE;
            bypass_q <= 1'b0;
        end else begin
            if (sel_id && (state_q == CAP_DR)) begin
                id_sr <= ID_VALUE;
            end else if (sel_id && (state_q == SH_DR)) begin
                id_sr <= {tap.tdi, id_sr[31:1]};
            end
            if (sel_byp && (state_q == CAP_DR)) begin
                bypass_q <= 1'b0;
            end else if (sel_byp && (state_q == SH_DR)) begin
                bypass_q <= tap.tdi;
            end
        end
    end

    // IR is stable on any edge entering UpdDR, so the current selection is the right one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bsr_update_q <= 1'b0;
        end else begin
            bsr_update_q <= (state_nxt == UPD_DR) && sel_bsr;
        end
    end

    always_comb begin
        dr_tdo = bypass_q;
        if (sel_bsr) begin
            dr_tdo = tap.bsr_tdo;
        end else if (sel_id) begin
            dr_tdo = id_sr[0];
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_en_q <= (state_q == SH_DR) || (state_q == SH_IR);
            case (state_q)
                SH_IR:   tdo_q <= ir_sr[0];
                SH_DR:   tdo_q <= dr_tdo;
                default: tdo_q <= 1'b0;
            endcase
        end
    end

    assign tap.tdo        = tdo_q;
    assign tap.tdo_en     = tdo_en_q;
    assign tap.bsr_clk_en = sel_bsr && ((state_q == CAP_DR) || (state_q == SH_DR));
    assign tap.bsr_shift  = sel_bsr && (state_q == SH_DR);
    assign tap.bsr_update = bsr_update_q;
    assign tap.bsr_mode   = (ir_q == OP_EXTEST);
    assign tap.state      = state_q;

endmodule
